// File: rtl/wrap_tally_display.sv
// Counts wrap-arounds of an upstream modulo counter into a two-digit BCD tally
// and scans the tally onto a multiplexed two-digit 7-segment display.
module wrap_tally_display #(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cnt_in,
  input  logic       enable,
  input  logic       clear,
  output logic [7:0] tally,
  output logic       wrap_pulse,
  output logic       ovf,
  output logic [1:0] dig_sel,
  output logic [6:0] seg
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [3:0]    cnt_q;
  logic          wrap;
  logic          bump;
  logic [3:0]    ones_q, tens_q;
  logic [3:0]    ones_nx, tens_nx;
  logic          roll;
  logic [DW-1:0] div_q;
  logic [3:0]    digit;

  // Any strict drop is a wrap, whatever the upstream step size.
  assign wrap = (cnt_in < cnt_q);
  assign bump = wrap && enable;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= 4'd0;
      wrap_pulse <= 1'b0;
    end else begin
      cnt_q      <= cnt_in;
      wrap_pulse <= bump;
    end
  end

  always_comb begin
    ones_nx = ones_q;
    tens_nx = tens_q;
    roll    = 1'b0;
    if (ones_q == 4'd9) begin
      ones_nx = 4'd0;
      if (tens_q == 4'd9) begin
        tens_nx = 4'd0;
        roll    = 1'b1;
      end else begin
        tens_nx = tens_q + 4'd1;
      end
    end else begin
      ones_nx = ones_q + 4'd1;
    end
  end

  // Clear wins over a same-edge wrap; the pulse above still fires.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
      ovf    <= 1'b0;
    end else if (bump) begin
      ones_q <= ones_nx;
      tens_q <= tens_nx;
      if (roll) ovf <= 1'b1;
    end
  end

  assign tally = {tens_q, ones_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      dig_sel <= 2'b01;
    end else if (div_q == DIV_LAST) begin
      div_q   <= '0;
      dig_sel <= {dig_sel[0], dig_sel[1]};
    end else begin
      div_q   <= div_q + DW'(1);
    end
  end

  // Decoded from registers only, so no input reaches seg combinationally.
  assign digit = dig_sel[1] ? tens_q : ones_q;

  always_comb begin
    seg = 7'h00;
    case (digit)
      4'd0: seg = 7'h3F;
      4'd1: seg = 7'h06;
      4'd2: seg = 7'h5B;
      4'd3: seg = 7'h4F;
      4'd4: seg = 7'h66;
      4'd5: seg = 7'h6D;
      4'd6: seg = 7'h7D;
      4'd7: seg = 7'h07;
      4'd8: seg = 7'h7F;
      4'd9: seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: tb/tb_wrap_tally_display.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against an integer-level model.
module tb_wrap_tally_display;

  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cnt_in = 4'd0;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] tally;
  logic       wrap_pulse;
  logic       ovf;
  logic [1:0] dig_sel;
  logic [6:0] seg;

  int errors = 0;
  int checks = 0;

  wrap_tally_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .enable(enable), .clear(clear),
    .tally(tally), .wrap_pulse(wrap_pulse), .ovf(ovf), .dig_sel(dig_sel), .seg(seg)
  );

  always #5 clk = ~clk;

  // Model: tally as a plain integer 0..99, display phase from edges since reset.
  int  m_tally = 0;
  bit  m_ovf = 0;
  bit  m_pulse = 0;
  int  m_prev = 0;
  int  m_cyc = 0;
  bit  m_valid = 0;
  logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always @(posedge clk) begin
    if (reset) begin
      m_tally = 0; m_ovf = 0; m_pulse = 0; m_prev = 0; m_cyc = 0; m_valid = 1;
    end else begin
      m_pulse = (int'(cnt_in) < m_prev) && enable;
      if (clear) begin
        m_tally = 0; m_ovf = 0;
      end else if (m_pulse) begin
        m_tally = m_tally + 1;
        if (m_tally == 100) begin m_tally = 0; m_ovf = 1; end
      end
      m_prev = int'(cnt_in);
      m_cyc  = m_cyc + 1;
    end
  end

  function automatic logic [7:0] m_bcd();
    return {4'(m_tally / 10), 4'(m_tally % 10)};
  endfunction

  function automatic bit m_tens_shown();
    return ((m_cyc / SCAN_DIV) % 2) == 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("tally", tally, m_bcd());
      check("ovf", ovf, m_ovf);
      check("wrap_pulse", wrap_pulse, m_pulse);
      check("dig_sel", dig_sel, m_tens_shown() ? 2'b10 : 2'b01);
      check("seg", seg, m_tens_shown() ? segtab[m_tally / 10] : segtab[m_tally % 10]);
    end
  end

  logic [3:0] last_c = 4'd0;

  task automatic apply(input bit r, input logic [3:0] c, input bit en, input bit clr);
    @(negedge clk);
    reset = r; cnt_in = c; enable = en; clear = clr;
    if (!r) last_c = c;
    else last_c = 4'd0;
    @(posedge clk);
    #1;
  endtask

  task automatic wraps(input int n);
    for (int i = 0; i < n; i++) begin
      apply(0, 4'd8, 1, 0);
      apply(0, 4'd0, 1, 0);
    end
  endtask

  initial begin
    apply(1, 4'd0, 0, 0);
    check("rst_tally", tally, 8'h00);
    check("rst_dig", dig_sel, 2'b01);
    check("rst_seg", seg, 7'h3F);

    // 1: rising sequence, one drop
    for (int v = 0; v <= 8; v += 2) begin
      apply(0, 4'(v), 1, 0);
      check("t1_nopulse", wrap_pulse, 1'b0);
    end
    apply(0, 4'd0, 1, 0);
    check("t1_pulse", wrap_pulse, 1'b1);
    check("t1_tally", tally, 8'h01);
    apply(0, 4'd0, 1, 0);
    check("t1_onecycle", wrap_pulse, 1'b0);

    // 2: 100 wraps from zero
    apply(1, 4'd0, 0, 0);
    wraps(99);
    check("t2_99", tally, 8'h99);
    check("t2_noovf", ovf, 1'b0);
    wraps(1);
    check("t2_roll", tally, 8'h00);
    check("t2_ovf", ovf, 1'b1);
    apply(0, 4'd0, 1, 1);
    check("t2_clr_ovf", ovf, 1'b0);
    check("t2_clr_tally", tally, 8'h00);

    // 3: disabled wraps ignored
    wraps(5);
    apply(0, 4'd8, 0, 0);
    apply(0, 4'd1, 0, 0);
    check("t3_nopulse", wrap_pulse, 1'b0);
    check("t3_tally", tally, 8'h05);
    apply(0, 4'd1, 1, 0);
    check("t3_reen", wrap_pulse, 1'b0);
    check("t3_tally2", tally, 8'h05);

    // 4: clear coincident with wrap
    apply(0, 4'd1, 1, 1);
    wraps(12);
    check("t4_pre", tally, 8'h12);
    apply(0, 4'd10, 1, 0);
    apply(0, 4'd0, 1, 1);
    check("t4_tally", tally, 8'h00);
    check("t4_pulse", wrap_pulse, 1'b1);
    apply(0, 4'd0, 1, 0);
    check("t4_pulse_off", wrap_pulse, 1'b0);

    // 5: scan of 37
    wraps(37);
    check("t5_tally", tally, 8'h37);
    for (int i = 0; i < 4 * SCAN_DIV; i++) begin
      apply(0, last_c, 1, 0);
      check("t5_seg", seg, m_tens_shown() ? 7'h4F : 7'h07);
    end

    // 6: reset mid-operation with ovf set
    apply(1, 4'd0, 0, 0);
    wraps(142);
    check("t6_pre_tally", tally, 8'h42);
    check("t6_pre_ovf", ovf, 1'b1);
    begin
      int n = 0;
      while (dig_sel != 2'b10 && n < 2 * SCAN_DIV + 2) begin
        apply(0, last_c, 1, 0);
        n++;
      end
      check("t6_pre_dig", dig_sel, 2'b10);
    end
    apply(1, 4'd5, 1, 0);
    check("t6_tally", tally, 8'h00);
    check("t6_ovf", ovf, 1'b0);
    check("t6_pulse", wrap_pulse, 1'b0);
    check("t6_dig", dig_sel, 2'b01);
    check("t6_seg", seg, 7'h3F);
    apply(0, 4'd9, 1, 0);
    check("t6_nowrap", wrap_pulse, 1'b0);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      apply($urandom_range(199) == 0,
            ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'(last_c + 4'd2),
            $urandom_range(3) != 0,
            $urandom_range(39) == 0);
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wrap_tally_display.md
Name: wrap_tally_display

Overview:
- Downstream consumer of the selectable-modulo 4-bit counter.
- Samples the counter's count value every clk rising edge and detects wrap-around (count drops). Tallies wraps in a 2-digit BCD register (00-99).
- Drives a 2-digit multiplexed 7-segment display of the tally.
- Gives the team a visible, checkable cascade stage: "tens of cycles of the modulo counter".

Parameters:
- SCAN_DIV, 4, clk cycles each display digit is held before switching. Legal range 2..65535. Internal divider width is clog2(SCAN_DIV).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- cnt_in  input  4  count value from the modulo counter. Any value 0-15 legal.
- enable  input  1  high: wraps increment the tally. Low: tally frozen.
- clear  input  1  synchronous clear of the tally and the overflow flag.
- tally  output  8  BCD tally: [7:4] tens, [3:0] ones.
- wrap_pulse  output  1  one-cycle strobe, high for the cycle after a detected wrap.
- ovf  output  1  sticky flag: tally rolled over from 99 to 00.
- dig_sel  output  2  one-hot, active-high digit enable: 01 = ones digit, 10 = tens digit.
- seg  output  7  active-high segments, bit order {g,f,e,d,c,b,a}.

Behaviour:
- Reset (reset=1 at a rising edge) sets:
  - cnt_q=0, tally=0x00, ovf=0, wrap_pulse=0
  - scan divider=0, dig_sel=01, seg=0x3F
  - Reset overrides every other input. Applying it mid-operation returns all state to these values on that edge, with no residual pulse.
- Sampling:
  - cnt_q <= cnt_in on every non-reset edge, regardless of enable and clear.
  - Because cnt_q resets to 0, the first sample after reset can never signal a wrap.
- Wrap detect (combinational): wrap = (cnt_in < cnt_q), unsigned 4-bit compare.
  - Any strict decrease counts as one wrap, including a drop caused by upstream reset.
  - Equal consecutive samples are not a wrap.
  - Upstream counts on both clock edges, so the sampled value typically steps by 2. Detection must not depend on step size.
- wrap_pulse <= wrap && enable. Registered; zero latency beyond the sampling edge. High for exactly one cycle per wrap event.
- Tally update, priority order at each edge: reset > clear > increment.
  - clear=1: tally <= 0x00 and ovf <= 0. Any simultaneous wrap does not increment the tally, but wrap_pulse is still asserted.
  - Otherwise, if wrap && enable, BCD increment:
    - ones 9 -> 0 with carry into tens.
    - tens 9 with carry -> tens 0: tally 0x99 -> 0x00 and ovf <= 1.
  - ovf stays 1 until reset or clear.
  - Tally digits never hold values A-F.
- Display scan:
  - Divider counts 0..SCAN_DIV-1 and free-runs independent of enable and clear.
  - On each edge where divider = SCAN_DIV-1: divider <= 0 and dig_sel toggles between 01 and 10.
  - Each digit is therefore shown for exactly SCAN_DIV cycles.
- seg is a combinational decode from registers only (no input-to-output combinational path). It shows the ones digit when dig_sel=01 and the tens digit when dig_sel=10.
- Decode table:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66
  - 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F
  - Any other value = 0x00 (unreachable).

Test Plan:
1. After reset, enable=1, drive cnt_in 0,2,4,6,8,0 on successive edges -> wrap_pulse high only in the cycle after the edge sampling the final 0; tally=0x01; no pulse on any earlier edge.
2. Generate 100 wraps with enable=1 -> tally reads 0x99 after the 99th wrap, then 0x00 with ovf=1 after the 100th. Then assert clear for 1 cycle -> ovf=0, tally=0x00.
3. tally=0x05 and enable=0, drive cnt_in 8 then 1 -> no wrap_pulse, tally stays 0x05. Re-enable with cnt_in held at 1 -> still no pulse.
4. tally=0x12, assert clear in the same cycle as cnt_in drops 10 -> 0 -> tally=0x00, wrap_pulse=1 for one cycle.
5. SCAN_DIV=4, tally=0x37 -> dig_sel=01 with seg=0x07 for 4 cycles, then dig_sel=10 with seg=0x4F for 4 cycles, repeating.
6. tally=0x42, ovf=1, dig_sel=10, assert reset for 1 cycle -> next cycle tally=0x00, ovf=0, wrap_pulse=0, dig_sel=01, seg=0x3F. A subsequent cnt_in of 9 produces no wrap.
